// File: rtl/elevator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elevator_pkg : shared state and direction encodings for the car controller
// Rev 1.0
// ----------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } car_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/elevator_car_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elevator_car_ctrl_if : call inputs and car status between building and car
// Rev 1.0
// ----------------------------------------------------------------------------
interface elevator_car_ctrl_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8
) ();
    localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

    logic [NUM_FLOORS-1:0] car_buttons;
    logic [NUM_FLOORS-1:0] hall_up;
    logic [NUM_FLOORS-1:0] hall_down;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  current_dir;
    logic                  moving;
    logic                  door_open;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output car_buttons, hall_up, hall_down,
        input  current_floor, current_dir, moving, door_open, arrive, pending
    );

    modport slave (
        input  car_buttons, hall_up, hall_down,
        output current_floor, current_dir, moving, door_open, arrive, pending
    );

endinterface
`default_nettype wire

// File: rtl/elevator_req_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elevator_req_scan : locates pending calls above / below / at a given floor
// Rev 1.0
// ----------------------------------------------------------------------------
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8
) (
    input  logic [NUM_FLOORS-1:0]                                     mask_i,
    input  logic [((NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1)-1:0]    floor_i,
    input  logic                                                      dir_i,
    output logic                                                      any_above_o,
    output logic                                                      any_below_o,
    output logic                                                      here_o,
    output logic                                                      ahead_o
);
    localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_i) any_above_o = any_above_o | mask_i[i];
            if (FLOOR_W'(i) < floor_i) any_below_o = any_below_o | mask_i[i];
        end
    end

    assign here_o  = mask_i[floor_i];
    assign ahead_o = (dir_i == DIR_UP) ? any_above_o : any_below_o;

endmodule
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elevator_car_ctrl : single-car collective SCAN controller with timed travel
// Rev 1.0
// ----------------------------------------------------------------------------
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    parameter int DEFAULT_FLOOR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_car_ctrl_if.slave   car_if
);
    localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TIMER_W-1:0]    TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] UP_VALID    = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_VALID    = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    car_state_e            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  arrive_q, arrive_d;
    logic [NUM_FLOORS-1:0] pend_car_q, pend_car_d;
    logic [NUM_FLOORS-1:0] pend_up_q, pend_up_d;
    logic [NUM_FLOORS-1:0] pend_dn_q, pend_dn_d;

    logic [NUM_FLOORS-1:0] car_in, up_in, dn_in, pend_all;
    logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn, blk_car, blk_up, blk_dn;
    logic [FLOOR_W-1:0]    floor_nxt;
    logic any_above_cur, any_below_cur, here_cur, ahead_cur;
    logic unused_above_nxt, unused_below_nxt, here_nxt, ahead_nxt;
    logic same_nxt, opp_nxt, stop_nxt, flip_nxt, door_reload;

    assign car_in    = car_if.car_buttons;
    assign up_in     = car_if.hall_up & UP_VALID;
    assign dn_in     = car_if.hall_down & DN_VALID;
    assign pend_all  = pend_car_q | pend_up_q | pend_dn_q;
    assign floor_nxt = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_cur (
        .mask_i(pend_all), .floor_i(floor_q), .dir_i(dir_q),
        .any_above_o(any_above_cur), .any_below_o(any_below_cur),
        .here_o(here_cur), .ahead_o(ahead_cur)
    );

    elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_nxt (
        .mask_i(pend_all), .floor_i(floor_nxt), .dir_i(dir_q),
        .any_above_o(unused_above_nxt), .any_below_o(unused_below_nxt),
        .here_o(here_nxt), .ahead_o(ahead_nxt)
    );

    // Stop on a car call or a same-direction hall call; at the end of the sweep
    // the opposite hall call is taken and the car reverses on the same edge.
    assign same_nxt    = (dir_q == DIR_UP) ? pend_up_q[floor_nxt] : pend_dn_q[floor_nxt];
    assign opp_nxt     = (dir_q == DIR_UP) ? pend_dn_q[floor_nxt] : pend_up_q[floor_nxt];
    assign stop_nxt    = pend_car_q[floor_nxt] | same_nxt | (here_nxt & ~ahead_nxt);
    assign flip_nxt    = ~ahead_nxt & opp_nxt;
    assign door_reload = car_in[floor_q] |
                         ((dir_q == DIR_UP) ? up_in[floor_q] : dn_in[floor_q]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            floor_q    <= FLOOR_W'(DEFAULT_FLOOR);
            dir_q      <= DIR_UP;
            timer_q    <= '0;
            arrive_q   <= 1'b0;
            pend_car_q <= '0;
            pend_up_q  <= '0;
            pend_dn_q  <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            arrive_q   <= arrive_d;
            pend_car_q <= pend_car_d;
            pend_up_q  <= pend_up_d;
            pend_dn_q  <= pend_dn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        arrive_d = 1'b0;
        clr_car  = '0;
        clr_up   = '0;
        clr_dn   = '0;
        blk_car  = '0;
        blk_up   = '0;
        blk_dn   = '0;
        unique case (state_q)
            IDLE: begin
                if (here_cur) begin
                    state_d          = DOOR;
                    timer_d          = DOOR_LOAD;
                    clr_car[floor_q] = 1'b1;
                    clr_up[floor_q]  = 1'b1;
                    clr_dn[floor_q]  = 1'b1;
                end else if (ahead_cur) begin
                    state_d = MOVE;
                    timer_d = TRAVEL_LOAD;
                end else if (any_above_cur | any_below_cur) begin
                    dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                    state_d = MOVE;
                    timer_d = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    floor_d = floor_nxt;
                    if (stop_nxt) begin
                        state_d            = DOOR;
                        arrive_d           = 1'b1;
                        timer_d            = DOOR_LOAD;
                        clr_car[floor_nxt] = 1'b1;
                        if (dir_q == DIR_UP) clr_up[floor_nxt] = 1'b1;
                        else                 clr_dn[floor_nxt] = 1'b1;
                        if (flip_nxt) begin
                            dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                            if (dir_q == DIR_UP) clr_dn[floor_nxt] = 1'b1;
                            else                 clr_up[floor_nxt] = 1'b1;
                        end
                    end else begin
                        timer_d = TRAVEL_LOAD;
                    end
                end
            end
            DOOR: begin
                // Calls for this floor in the travel direction just keep the door open.
                blk_car[floor_q] = 1'b1;
                if (dir_q == DIR_UP) blk_up[floor_q] = 1'b1;
                else                 blk_dn[floor_q] = 1'b1;
                if (door_reload)           timer_d = DOOR_LOAD;
                else if (timer_q == '0)    state_d = IDLE;
                else                       timer_d = timer_q - TIMER_W'(1);
            end
            default: state_d = IDLE;
        endcase
        pend_car_d = (pend_car_q | (car_in & ~blk_car)) & ~clr_car;
        pend_up_d  = (pend_up_q  | (up_in  & ~blk_up))  & ~clr_up;
        pend_dn_d  = (pend_dn_q  | (dn_in  & ~blk_dn))  & ~clr_dn;
    end

    always_comb begin
        car_if.current_floor = floor_q;
        car_if.current_dir   = dir_q;
        car_if.moving        = (state_q == MOVE);
        car_if.door_open     = (state_q == DOOR);
        car_if.arrive        = arrive_q;
        car_if.pending       = pend_all;
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_elevator_car_ctrl : directed scenarios plus random calls vs. a call-list model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_elevator_car_ctrl;
    localparam int N = 8;
    localparam int T = 4;
    localparam int D = 3;
    localparam int M_IDLE   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DOOR   = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    elevator_car_ctrl_if #(.NUM_FLOORS(N)) bus ();

    elevator_car_ctrl #(
        .NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D), .DEFAULT_FLOOR(0)
    ) dut (
        .clk(clk), .reset(rst), .car_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: call lists as arrays, countdowns in "edges remaining".
    bit m_car[N];
    bit m_up[N];
    bit m_dn[N];
    int m_floor;
    bit m_dir;
    int m_mode;
    int m_left;
    bit m_arrive;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int f);
        logic [N-1:0] v;
        v = '0;
        v[f] = 1'b1;
        return v;
    endfunction

    function automatic bit calls_beyond(input int f, input bit up);
        bit r;
        r = 0;
        for (int i = 0; i < N; i++)
            if ((up && i > f) || (!up && i < f)) r = r | m_car[i] | m_up[i] | m_dn[i];
        return r;
    endfunction

    function automatic logic [N-1:0] m_pending();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_car[i] | m_up[i] | m_dn[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_car[i] = 0; m_up[i] = 0; m_dn[i] = 0; end
        m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_left = 0; m_arrive = 0;
    endtask

    task automatic model_step(input logic [N-1:0] c, input logic [N-1:0] u, input logic [N-1:0] d);
        bit cc[N], cu[N], cd[N], bc[N], bu[N], bd[N];
        int f;
        bit same, opp, beyond;
        for (int i = 0; i < N; i++) begin
            cc[i] = 0; cu[i] = 0; cd[i] = 0; bc[i] = 0; bu[i] = 0; bd[i] = 0;
        end
        m_arrive = 0;
        if (m_mode == M_IDLE) begin
            f = m_floor;
            if (m_car[f] || m_up[f] || m_dn[f]) begin
                m_mode = M_DOOR; m_left = D; cc[f] = 1; cu[f] = 1; cd[f] = 1;
            end else if (calls_beyond(f, m_dir)) begin
                m_mode = M_TRAVEL; m_left = T;
            end else if (calls_beyond(f, !m_dir)) begin
                m_dir = !m_dir; m_mode = M_TRAVEL; m_left = T;
            end
        end else if (m_mode == M_TRAVEL) begin
            m_left--;
            if (m_left == 0) begin
                f = m_dir ? m_floor + 1 : m_floor - 1;
                m_floor = f;
                same   = m_dir ? m_up[f] : m_dn[f];
                opp    = m_dir ? m_dn[f] : m_up[f];
                beyond = calls_beyond(f, m_dir);
                if (m_car[f] || same || !beyond) begin
                    m_mode = M_DOOR; m_left = D; m_arrive = 1; cc[f] = 1;
                    if (m_dir) cu[f] = 1; else cd[f] = 1;
                    if (!beyond && opp) begin
                        if (m_dir) cd[f] = 1; else cu[f] = 1;
                        m_dir = !m_dir;
                    end
                end else begin
                    m_left = T;
                end
            end
        end else begin
            f = m_floor;
            bc[f] = 1;
            if (m_dir) bu[f] = 1; else bd[f] = 1;
            if (c[f] || (m_dir && u[f] && f != N-1) || (!m_dir && d[f] && f != 0)) begin
                m_left = D;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_car[i] = (m_car[i] | (c[i] & !bc[i])) & !cc[i];
            m_up[i]  = (m_up[i]  | (u[i] & !bu[i] & (i != N-1))) & !cu[i];
            m_dn[i]  = (m_dn[i]  | (d[i] & !bd[i] & (i != 0))) & !cd[i];
        end
    endtask

    task automatic compare_all();
        chk_eq("floor",   bus.current_floor, m_floor);
        chk_eq("dir",     bus.current_dir,   m_dir);
        chk_eq("moving",  bus.moving,        m_mode == M_TRAVEL);
        chk_eq("door",    bus.door_open,     m_mode == M_DOOR);
        chk_eq("arrive",  bus.arrive,        m_arrive);
        chk_eq("pending", bus.pending,       m_pending());
    endtask

    task automatic tick(input logic [N-1:0] c, input logic [N-1:0] u, input logic [N-1:0] d);
        bus.car_buttons = c;
        bus.hall_up     = u;
        bus.hall_down   = d;
        @(posedge clk);
        model_step(c, u, d);
        #1;
        compare_all();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick('0, '0, '0);
    endtask

    // Called just after an edge: reset asserts and releases between edges.
    task automatic async_reset();
        bus.car_buttons = '0;
        bus.hall_up     = '0;
        bus.hall_down   = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #2 rst = 1'b0;
    endtask

    initial begin
        bit found;
        int r, k;
        logic [N-1:0] c, u, d;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.car_buttons = '0;
        bus.hall_up     = '0;
        bus.hall_down   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk_eq("reset_dir", bus.current_dir, 1);
        @(negedge clk);
        rst = 1'b0;

        // One car call three floors up: timing of travel, arrival and door.
        tick(onehot(3), '0, '0);
        for (int e = 1; e <= 16; e++) begin
            tick('0, '0, '0);
            if (e == 1)  chk_eq("t2_moving_e1", bus.moving, 1);
            if (e == 4)  chk_eq("t2_floor_e4", bus.current_floor, 0);
            if (e == 5)  chk_eq("t2_floor_e5", bus.current_floor, 1);
            if (e == 9)  chk_eq("t2_floor_e9", bus.current_floor, 2);
            if (e == 13) begin
                chk_eq("t2_floor_e13", bus.current_floor, 3);
                chk_eq("t2_arrive_e13", bus.arrive, 1);
                chk_eq("t2_pend_e13", bus.pending, 0);
            end
            if (e == 14) chk_eq("t2_arrive_e14", bus.arrive, 0);
            if (e == 15) chk_eq("t2_door_e15", bus.door_open, 1);
            if (e == 16) chk_eq("t2_door_e16", bus.door_open, 0);
        end

        // Door reload at the last door cycle.
        tick(onehot(3), '0, '0);
        found = 0;
        k = 0;
        while (!found && k < 20) begin
            if (m_mode == M_DOOR && m_left == 1) found = 1;
            else tick('0, '0, '0);
            k++;
        end
        chk_eq("t5_reach", found, 1);
        tick(onehot(3), '0, '0);
        for (int e = 0; e < 2; e++) begin
            tick('0, '0, '0);
            chk_eq("t5_door_held", bus.door_open, 1);
            chk_eq("t5_pend3", bus.pending[3], 0);
        end
        tick('0, '0, '0);
        chk_eq("t5_door_closed", bus.door_open, 0);

        // At floor 3 heading up: the upper call is served before the lower one.
        idle_ticks(3);
        tick(onehot(1) | onehot(6), '0, '0);
        k = 0;
        while (bus.current_floor != 6 && k < 40) begin tick('0, '0, '0); k++; end
        chk_eq("t4_first_stop", bus.current_floor, 6);
        idle_ticks(60);
        chk_eq("t4_floor", bus.current_floor, 1);
        chk_eq("t4_pending", bus.pending, 0);

        // Car call at 2 plus down call at 5: reversal on arrival at 5.
        async_reset();
        tick(onehot(2), '0, onehot(5));
        idle_ticks(50);
        chk_eq("t3_floor", bus.current_floor, 5);
        chk_eq("t3_dir", bus.current_dir, 0);
        chk_eq("t3_pending", bus.pending, 0);

        // Down call at 4 is passed on the way up and served on the way back.
        async_reset();
        tick(onehot(6), '0, onehot(4));
        idle_ticks(60);
        chk_eq("t6_floor", bus.current_floor, 4);
        chk_eq("t6_dir", bus.current_dir, 0);
        chk_eq("t6_pending", bus.pending, 0);

        // Reset while travelling at floor 3.
        async_reset();
        tick(onehot(6), '0, '0);
        found = 0;
        k = 0;
        while (!found && k < 40) begin
            if (m_floor == 3 && m_mode == M_TRAVEL) found = 1;
            else tick('0, '0, '0);
            k++;
        end
        chk_eq("t1_reach", found, 1);
        async_reset();
        chk_eq("t1_floor", bus.current_floor, 0);
        chk_eq("t1_moving", bus.moving, 0);
        chk_eq("t1_pending", bus.pending, 0);

        // Random calls, including ignored end-floor hall bits and mid-run resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            c = '0; u = '0; d = '0;
            r = $urandom_range(0, 9);
            for (int p = 0; p < ((r == 0) ? 2 : (r < 3) ? 1 : 0); p++) begin
                k = $urandom_range(0, N-1);
                case ($urandom_range(0, 2))
                    0: c = c | onehot(k);
                    1: u = u | onehot(k);
                    default: d = d | onehot(k);
                endcase
            end
            tick(c, u, d);
            if ((cyc % 700) == 350 && m_mode == M_TRAVEL) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
Parametrised single-car controller for the next generation of the elevator car. It generalises the fixed 7-floor, single-request-port design to NUM_FLOORS floors with separate hall-up and hall-down call masks. It adds timed floor-to-floor travel and a timed door state. It latches car and hall calls into pending masks and runs a collective SCAN policy: keep direction while calls lie ahead, reverse otherwise. It drives floor, direction, motion and door status to the building-level logic.

Parameters:
NUM_FLOORS, 8, number of serviced floors (2..64); FLOOR_W = $clog2(NUM_FLOORS) is a derived localparam
TRAVEL_CYCLES, 4, clock cycles per one-floor move (>=1)
DOOR_CYCLES, 3, clock cycles the door stays open (>=1)
DEFAULT_FLOOR, 0, floor the car occupies after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
car_buttons  input  NUM_FLOORS  in-car floor button pulses, one bit per floor
hall_up  input  NUM_FLOORS  hall up-call pulses; bit NUM_FLOORS-1 ignored
hall_down  input  NUM_FLOORS  hall down-call pulses; bit 0 ignored
current_floor  output  FLOOR_W  registered car position
current_dir  output  1  1=up, 0=down
moving  output  1  high while in MOVE
door_open  output  1  high while in DOOR
arrive  output  1  one-cycle pulse on the edge the car stops at a floor
pending  output  NUM_FLOORS  OR of the three pending masks

Behaviour:
- Reset (async assert, sync release): state IDLE; current_floor=DEFAULT_FLOOR; current_dir=1; timer=0; all pending masks 0; moving, door_open and arrive all 0.
- Request latch: every edge, pend_x |= input_x, with clear having priority for bits served on that same edge. Pulses are sampled on the edge; level inputs re-latch every cycle.
- The scan helper produces any_above, any_below and here relative to current_floor over (car|up|down).
- IDLE:
  - here=1 -> DOOR. Clear all three bits at current_floor. timer=DOOR_CYCLES-1.
  - Else, calls ahead in current_dir -> MOVE, timer=TRAVEL_CYCLES-1.
  - Else, calls in the opposite direction -> flip current_dir on the same edge, then MOVE.
  - Else stay in IDLE.
- MOVE:
  - Timer decrements each edge.
  - At timer=0, current_floor steps by ±1 on that edge. The stop test is evaluated on the new floor f:
    - Stop if car[f], or hall call in current_dir at f, or no calls beyond f in current_dir.
    - In the last case, current_dir flips when the opposite hall call at f is served.
  - Stop: -> DOOR, arrive=1, timer=DOOR_CYCLES-1. Clear car[f] and the hall bit(s) served.
  - No stop: reload the timer and continue.
  - The floor never leaves 0..NUM_FLOORS-1, because the car only moves toward a pending call.
- DOOR:
  - Timer decrements each edge; at timer=0 -> IDLE.
  - A car or same-direction hall pulse for current_floor arriving in DOOR reloads timer=DOOR_CYCLES-1 and is not latched.
  - Opposite-direction hall calls are latched normally.
- Latency: a call one floor away, issued while IDLE, produces the floor change and DOOR entry TRAVEL_CYCLES+1 edges after the sampling edge.
- Simultaneous set and clear of the same bit: clear wins only for bits served on that edge; the reload rule covers the door case.
- Reset mid-operation: all state is abandoned and the car returns to DEFAULT_FLOOR immediately.

Decomposition:
- Package elevator_pkg:
  - car_state_e {IDLE, MOVE, DOOR}
  - DIR_UP=1'b1, DIR_DOWN=1'b0
- Sub-module elevator_req_scan (combinational, parametrised by NUM_FLOORS):
  - inputs: request mask, floor, dir
  - outputs: any_above, any_below, here, ahead
  - instantiated once on current_floor and once on the next floor for the stop test

Test Plan (defaults N=8, T=4, D=3, start floor 0):
1. Assert and release reset mid-MOVE at floor 3 -> floor=0, dir=1, moving=0, door_open=0, pending=0 asynchronously.
2. car_buttons[3] pulsed at E0 -> moving from E1; floor 1/2/3 at E5/E9/E13; arrive at E13; door_open for E13-E15; IDLE at E16; pending[3]=0 from E13.
3. From floor 0, car_buttons[2] and hall_down[5] together -> stops at 2 (dir=1), then at 5 with dir flipped to 0 and pending=0.
4. Car IDLE at floor 3 with dir=1; car_buttons[1] and [6] pulsed together -> serves 6 first, then reverses and serves 1.
5. In DOOR at floor 3 with timer=0, pulse car_buttons[3] -> door_open stays high 3 more cycles and pending[3] remains 0.
6. Moving up past floor 4 with hall_down[4] pending and car_buttons[6] pending -> no stop at 4; stop at 6, reverse, stop at 4 clearing hall_down[4].
